// File: rtl/pontuacao_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pontuacao_pkg
// Purpose  : Shared types and constants for the round-scoring block: FSM
//            state encoding, default per-level round table and the helper
//            that turns a round count into its triangular score divisor.
// Revision : 1.0 - initial release
// ============================================================================
package pontuacao_pkg;

  // Scoring FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Default round table, one entry per difficulty level
  localparam int ROUNDS_L0_DEF = 8;
  localparam int ROUNDS_L1_DEF = 16;
  localparam int ROUNDS_L2_DEF = 24;
  localparam int ROUNDS_L3_DEF = 32;

  // S = N(N+1)/2: sum of round weights, so a full error-free game adds up
  // to (about) MAX_SCORE
  function automatic int soma_rodadas(input int n);
    return (n * (n + 1)) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pontuacao_parametrizada_if.sv
`default_nettype none
// ============================================================================
// Module   : pontuacao_parametrizada_if
// Purpose  : Round-result channel (valid/ready handshake plus level, round
//            index and error count) between the game logic and the scorer.
// Revision : 1.0 - initial release
// ============================================================================
interface pontuacao_parametrizada_if #(
  parameter int ROUND_W = 5,
  parameter int ERR_W   = 4
);
  logic               round_valid;
  logic               round_ready;
  logic [1:0]         nivel;
  logic [ROUND_W-1:0] round_idx;
  logic [ERR_W-1:0]   erros;

  modport master (
    output round_valid, nivel, round_idx, erros,
    input  round_ready
  );

  modport slave (
    input  round_valid, nivel, round_idx, erros,
    output round_ready
  );
endinterface
`default_nettype wire

// File: rtl/divisor_serial.sv
`default_nettype none
// ============================================================================
// Module   : divisor_serial
// Purpose  : Restoring divider, one quotient bit per cycle. The caller
//            guarantees the quotient fits in QW bits, so the divisor is
//            pre-shifted by QW-1 and walked down one position per cycle.
//            done pulses for one cycle QW cycles after start; a new start
//            always restarts the operation.
// Revision : 1.0 - initial release
// ============================================================================
module divisor_serial #(
  parameter int DW = 19,
  parameter int QW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [QW-1:0] quotient
);
  localparam int RW = DW + QW;
  localparam int CW = $clog2(QW + 1);

  logic [RW-1:0] rem_q, rem_d;
  logic [RW-1:0] dsh_q, dsh_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Load on start, otherwise one trial subtraction per cycle while busy
  always_comb begin
    rem_d  = rem_q;
    dsh_d  = dsh_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = RW'(dividend);
      dsh_d  = RW'(divisor) << (QW - 1);
      quo_d  = '0;
      cnt_d  = CW'(QW);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (rem_q >= dsh_q) begin
        rem_d = rem_q - dsh_q;
        quo_d = {quo_q[QW-2:0], 1'b1};
      end else begin
        quo_d = {quo_q[QW-2:0], 1'b0};
      end
      dsh_d = dsh_q >> 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dsh_q  <= dsh_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule
`default_nettype wire

// File: rtl/pontuacao_parametrizada.sv
`default_nettype none
// ============================================================================
// Module   : pontuacao_parametrizada
// Purpose  : Per-round game scorer. Each accepted round adds
//            floor((idx+1)*MAX_SCORE/S) minus an error penalty, saturating
//            at MAX_SCORE; an error-free game finishes on exactly MAX_SCORE.
//            Fixed latency of QW+2 cycles from handshake to pontos_valid.
// Options  : define STREAK_BONUS_EN to enable the zero-error streak bonus
//            (parameters STREAK_LEN, STREAK_BONUS).
// Revision : 1.0 - initial release
// ============================================================================
module pontuacao_parametrizada
  import pontuacao_pkg::*;
#(
  parameter int SCORE_W      = 7,
  parameter int MAX_SCORE    = 100,
  parameter int ROUND_W      = 5,
  parameter int ERR_W        = 4,
  parameter int PENALTY_UNIT = 2,
`ifdef STREAK_BONUS_EN
  parameter int STREAK_LEN   = 4,
  parameter int STREAK_BONUS = 5,
`endif
  parameter int ROUNDS_L0    = ROUNDS_L0_DEF,
  parameter int ROUNDS_L1    = ROUNDS_L1_DEF,
  parameter int ROUNDS_L2    = ROUNDS_L2_DEF,
  parameter int ROUNDS_L3    = ROUNDS_L3_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      novo_jogo,
  pontuacao_parametrizada_if.slave  rnd,
  output logic [SCORE_W-1:0]        pontos,
  output logic                      pontos_valid,
  output logic                      erro_rodada,
  output logic                      jogo_fim,
  output logic [ROUND_W-1:0]        streak
);
  localparam int QW     = SCORE_W + 1;
  localparam int DIV_W  = 2 * ROUND_W + SCORE_W + 2;
  localparam int NW     = ROUND_W + 1;
  localparam int TOT_W  = ERR_W + ROUND_W;
  localparam int PEN_W  = ERR_W + $clog2(PENALTY_UNIT + 1);
  localparam int CMP_W  = QW + PEN_W;
  localparam int SW1    = SCORE_W + 1;
  localparam logic [SW1-1:0] C_MAX = SW1'(MAX_SCORE);

  // Rounds per game for a level
  function automatic logic [NW-1:0] rounds_of(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return NW'(ROUNDS_L0);
      2'd1:    return NW'(ROUNDS_L1);
      2'd2:    return NW'(ROUNDS_L2);
      default: return NW'(ROUNDS_L3);
    endcase
  endfunction

  // Score divisor for a level, folded to a constant per branch
  function automatic logic [DIV_W-1:0] s_of(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return DIV_W'(soma_rodadas(ROUNDS_L0));
      2'd1:    return DIV_W'(soma_rodadas(ROUNDS_L1));
      2'd2:    return DIV_W'(soma_rodadas(ROUNDS_L2));
      default: return DIV_W'(soma_rodadas(ROUNDS_L3));
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          nivel_q, nivel_d;
  logic [ROUND_W-1:0]  idx_q, idx_d;
  logic [ERR_W-1:0]    erros_q, erros_d;
  logic [QW-1:0]       base_q, base_d;
  logic [SCORE_W-1:0]  pontos_q, pontos_d;
  logic                pv_q, pv_d;
  logic                er_q, er_d;
  logic                fim_q, fim_d;
  logic                ready_q, ready_d;
  logic [TOT_W-1:0]    tot_q, tot_d;
`ifdef STREAK_BONUS_EN
  logic [ROUND_W-1:0]  streak_q, streak_d;
  logic [ROUND_W-1:0]  streak_next;
  logic [SW1-1:0]      sum_bonus;
`endif

  logic                handshake;
  logic                in_range;
  logic                div_start;
  logic                div_done;
  logic [QW-1:0]       div_quot;
  logic [DIV_W-1:0]    dividend;

  logic [PEN_W-1:0]    penalty;
  logic [CMP_W-1:0]    gain;
  logic [SW1-1:0]      sum_raw, score_acc;
  logic [TOT_W:0]      tot_sum;
  logic [TOT_W-1:0]    tot_next;
  logic                last_round;
  logic [SCORE_W-1:0]  score_next;

  assign handshake = rnd.round_valid && ready_q;
  assign in_range  = NW'(rnd.round_idx) < rounds_of(rnd.nivel);
  assign dividend  = (DIV_W'(rnd.round_idx) + DIV_W'(1)) * DIV_W'(MAX_SCORE);

  // The divider starts straight off the handshake so the whole round fits
  // in QW+2 cycles
  divisor_serial #(
    .DW (DIV_W),
    .QW (QW)
  ) u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (s_of(rnd.nivel)),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Score arithmetic for the round being committed in UPDATE
  always_comb begin
    penalty   = PEN_W'(erros_q) * PEN_W'(PENALTY_UNIT);
    gain      = (CMP_W'(base_q) > CMP_W'(penalty)) ?
                (CMP_W'(base_q) - CMP_W'(penalty)) : '0;
    // gain never exceeds base, which never exceeds MAX_SCORE
    sum_raw   = SW1'(pontos_q) + SW1'(gain);
    score_acc = (sum_raw > C_MAX) ? C_MAX : sum_raw;
`ifdef STREAK_BONUS_EN
    streak_next = (erros_q == '0) ?
                  ((streak_q == '1) ? streak_q : streak_q + ROUND_W'(1)) : '0;
    sum_bonus   = score_acc + SW1'(STREAK_BONUS);
    if ((erros_q == '0) && ((int'(streak_next) % STREAK_LEN) == 0)) begin
      score_acc = (sum_bonus > C_MAX) ? C_MAX : sum_bonus;
    end
`endif
    tot_sum    = {1'b0, tot_q} + (TOT_W + 1)'(erros_q);
    tot_next   = tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];
    last_round = (NW'(idx_q) + NW'(1)) == rounds_of(nivel_q);
    score_next = (last_round && (tot_next == '0)) ?
                 SCORE_W'(MAX_SCORE) : score_acc[SCORE_W-1:0];
  end

  // FSM next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    nivel_d   = nivel_q;
    idx_d     = idx_q;
    erros_d   = erros_q;
    base_d    = base_q;
    pontos_d  = pontos_q;
    pv_d      = 1'b0;
    er_d      = 1'b0;
    fim_d     = fim_q;
    tot_d     = tot_q;
`ifdef STREAK_BONUS_EN
    streak_d  = streak_q;
`endif
    div_start = 1'b0;
    if (novo_jogo) begin
      state_d  = IDLE;
      pontos_d = '0;
      tot_d    = '0;
      fim_d    = 1'b0;
`ifdef STREAK_BONUS_EN
      streak_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            nivel_d = rnd.nivel;
            idx_d   = rnd.round_idx;
            erros_d = rnd.erros;
            if (in_range) begin
              div_start = 1'b1;
              state_d   = CALC;
            end else begin
              er_d = 1'b1;
            end
          end
        end
        CALC: begin
          if (div_done) begin
            base_d  = div_quot;
            state_d = UPDATE;
          end
        end
        UPDATE: begin
          pontos_d = score_next;
          pv_d     = 1'b1;
          tot_d    = tot_next;
          fim_d    = fim_q | last_round;
`ifdef STREAK_BONUS_EN
          streak_d = streak_next;
`endif
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    ready_d = (state_d == IDLE) && !fim_d;
  end

  // FSM state and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      nivel_q  <= '0;
      idx_q    <= '0;
      erros_q  <= '0;
      base_q   <= '0;
      pontos_q <= '0;
      pv_q     <= 1'b0;
      er_q     <= 1'b0;
      fim_q    <= 1'b0;
      ready_q  <= 1'b1;
      tot_q    <= '0;
`ifdef STREAK_BONUS_EN
      streak_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      nivel_q  <= nivel_d;
      idx_q    <= idx_d;
      erros_q  <= erros_d;
      base_q   <= base_d;
      pontos_q <= pontos_d;
      pv_q     <= pv_d;
      er_q     <= er_d;
      fim_q    <= fim_d;
      ready_q  <= ready_d;
      tot_q    <= tot_d;
`ifdef STREAK_BONUS_EN
      streak_q <= streak_d;
`endif
    end
  end

  assign rnd.round_ready = ready_q;
  assign pontos          = pontos_q;
  assign pontos_valid    = pv_q;
  assign erro_rodada     = er_q;
  assign jogo_fim        = fim_q;
`ifdef STREAK_BONUS_EN
  assign streak          = streak_q;
`else
  assign streak          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pontuacao_parametrizada.sv
`default_nettype none
// ============================================================================
// Module   : tb_pontuacao_parametrizada
// Purpose  : Directed bench for the round scorer with an expected-result
//            queue filled at handshake and drained on pontos_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pontuacao_parametrizada;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       novo_jogo = 1'b0;
  logic [6:0] pontos;
  logic       pontos_valid;
  logic       erro_rodada;
  logic       jogo_fim;
  logic [4:0] streak;

  always #5 clock = ~clock;

  pontuacao_parametrizada_if #(.ROUND_W(5), .ERR_W(4)) rif ();

  pontuacao_parametrizada dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .novo_jogo    (novo_jogo),
    .rnd          (rif.slave),
    .pontos       (pontos),
    .pontos_valid (pontos_valid),
    .erro_rodada  (erro_rodada),
    .jogo_fim     (jogo_fim),
    .streak       (streak)
  );

  typedef struct {
    int pontos;
    bit fim;
    int streak;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_pontos = 0;
  int   m_tot    = 0;
  int   m_streak = 0;
  bit   m_fim    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int rounds_tab(input int lvl);
    case (lvl)
      0:       return 8;
      1:       return 16;
      2:       return 24;
      default: return 32;
    endcase
  endfunction

  function automatic int exp_streak();
`ifdef STREAK_BONUS_EN
    return m_streak;
`else
    return 0;
`endif
  endfunction

  task automatic model_clear();
    m_pontos = 0;
    m_tot    = 0;
    m_streak = 0;
    m_fim    = 0;
  endtask

  // Reference scoring of one in-range round
  task automatic model_round(input int lvl, input int idx, input int e, output exp_t x);
    int n, s, base, pen, gain, p;
    n    = rounds_tab(lvl);
    s    = n * (n + 1) / 2;
    base = ((idx + 1) * 100) / s;
    pen  = e * 2;
    gain = (base > pen) ? base - pen : 0;
    m_tot = m_tot + e;
    if (m_tot > 511) m_tot = 511;
    if (e == 0) m_streak++; else m_streak = 0;
    p = m_pontos + gain;
    if (p > 100) p = 100;
`ifdef STREAK_BONUS_EN
    if (e == 0 && (m_streak % 4) == 0) begin
      p = p + 5;
      if (p > 100) p = 100;
    end
`endif
    if (idx + 1 == n) begin
      m_fim = 1;
      if (m_tot == 0) p = 100;
    end
    m_pontos = p;
    x.pontos = p;
    x.fim    = m_fim;
    x.streak = exp_streak();
  endtask

  task automatic send_round(input int lvl, input int idx, input int e, input string tag);
    exp_t x;
    int   k;
    @(negedge clock);
    chk({tag, "_ready"}, 32'(rif.round_ready), 1);
    rif.round_valid = 1'b1;
    rif.nivel       = 2'(lvl);
    rif.round_idx   = 5'(idx);
    rif.erros       = 4'(e);
    if (idx >= rounds_tab(lvl)) begin
      @(negedge clock);
      rif.round_valid = 1'b0;
      chk({tag, "_erro"}, 32'(erro_rodada), 1);
      chk({tag, "_pontos"}, 32'(pontos), m_pontos);
      @(negedge clock);
      chk({tag, "_erro_pulse"}, 32'(erro_rodada), 0);
      chk({tag, "_no_valid"}, 32'(pontos_valid), 0);
    end else begin
      model_round(lvl, idx, e, x);
      sb.push_back(x);
      @(negedge clock);
      rif.round_valid = 1'b0;
      k = 0;
      for (int c = 1; c <= 20 && k == 0; c++) begin
        @(negedge clock);
        if (pontos_valid === 1'b1) k = c;
      end
      chk({tag, "_latency"}, k, 10);
      x = sb.pop_front();
      chk({tag, "_pontos"}, 32'(pontos), x.pontos);
      chk({tag, "_fim"}, 32'(jogo_fim), 32'(x.fim));
      chk({tag, "_streak"}, 32'(streak), x.streak);
      @(negedge clock);
      chk({tag, "_valid_pulse"}, 32'(pontos_valid), 0);
    end
  endtask

  task automatic new_game(input string tag);
    @(negedge clock);
    novo_jogo = 1'b1;
    @(negedge clock);
    novo_jogo = 1'b0;
    model_clear();
    chk({tag, "_pontos"}, 32'(pontos), 0);
    chk({tag, "_ready"}, 32'(rif.round_ready), 1);
    chk({tag, "_fim"}, 32'(jogo_fim), 0);
    chk({tag, "_streak"}, 32'(streak), 0);
  endtask

  task automatic expect_no_valid(input string tag);
    int hits = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (pontos_valid !== 1'b0) hits++;
    end
    chk(tag, hits, 0);
  endtask

  initial begin
    rif.round_valid = 1'b0;
    rif.nivel       = 2'd0;
    rif.round_idx   = '0;
    rif.erros       = '0;
    repeat (3) @(negedge clock);
    chk("rst_pontos", 32'(pontos), 0);
    chk("rst_valid", 32'(pontos_valid), 0);
    chk("rst_erro", 32'(erro_rodada), 0);
    chk("rst_fim", 32'(jogo_fim), 0);
    chk("rst_streak", 32'(streak), 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_ready", 32'(rif.round_ready), 1);

    // Full error-free level-0 game: 2,7,15,26,39,55,74 then perfect 100
    for (int i = 0; i < 8; i++) send_round(0, i, 0, $sformatf("l0_r%0d", i));
    chk("perfect_pontos", 32'(pontos), 100);
    chk("perfect_ready", 32'(rif.round_ready), 0);
    chk("perfect_fim", 32'(jogo_fim), 1);

    new_game("ng1");
    send_round(0, 7, 3, "pen3");            // 22 - 6 = 16
    new_game("ng2");
    send_round(0, 0, 0, "pre_pen15");       // 2
    send_round(0, 7, 15, "pen15");          // penalty 30 > 22: unchanged

    new_game("ng3");
    send_round(1, 10, 1, "l1_r10");         // 1100/136 = 8, minus 2
    send_round(1, 16, 0, "l1_reject");

    // Clear during the divide: the in-flight round is dropped
    @(negedge clock);
    rif.round_valid = 1'b1;
    rif.nivel       = 2'd1;
    rif.round_idx   = 5'd5;
    rif.erros       = 4'd0;
    @(negedge clock);
    rif.round_valid = 1'b0;
    repeat (3) @(negedge clock);
    novo_jogo = 1'b1;
    @(negedge clock);
    novo_jogo = 1'b0;
    model_clear();
    chk("midcalc_ready", 32'(rif.round_ready), 1);
    chk("midcalc_pontos", 32'(pontos), 0);
    expect_no_valid("midcalc_dropped");

    // Clear wins over a simultaneous round offer
    @(negedge clock);
    rif.round_valid = 1'b1;
    novo_jogo       = 1'b1;
    @(negedge clock);
    rif.round_valid = 1'b0;
    novo_jogo       = 1'b0;
    expect_no_valid("clear_priority");

    send_round(3, 31, 0, "l3_last");        // base 6, error-free game -> 100

    new_game("ng4");
    send_round(0, 1, 0, "pre_reset");       // 5
    @(negedge clock);
    rif.round_valid = 1'b1;
    rif.nivel       = 2'd0;
    rif.round_idx   = 5'd2;
    rif.erros       = 4'd0;
    @(negedge clock);
    rif.round_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    model_clear();
    chk("arst_pontos", 32'(pontos), 0);
    chk("arst_ready", 32'(rif.round_ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
    expect_no_valid("arst_dropped");

    send_round(2, 0, 0, "l2_r0");           // 100/300 = 0
    send_round(2, 23, 0, "l2_last");        // error-free -> 100

`ifdef STREAK_BONUS_EN
    new_game("ng5");
    for (int i = 0; i < 4; i++) send_round(0, i, 0, $sformatf("bonus_r%0d", i));
    chk("bonus_pontos", 32'(pontos), 31);
    chk("bonus_streak", 32'(streak), 4);
    send_round(0, 4, 1, "bonus_break");
    chk("bonus_streak_reset", 32'(streak), 0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
